// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state encoding, LFSR constants and helpers for the Simon sequencer
package simon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_PLAY_ON,
        S_PLAY_GAP,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Index of the highest set bit; callers only rely on it for one-hot inputs.
    function automatic logic [4:0] onehot_to_index(input logic [31:0] onehot);
        logic [4:0] index;
        index = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) index = 5'(i);
        end
        return index;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// rtl/simon_lfsr.sv - free-running 16-bit Galois LFSR feeding new notes
module simon_lfsr
    import simon_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] Q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= LFSR_SEED;
        end else begin
            Q <= {1'b0, Q[15:1]} ^ (Q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Simon game control: grows, plays back and checks the note sequence
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int DATA_WIDTH    = 2,
    parameter int DEPTH         = 16,
    parameter int NOTE_TICKS    = 12_500_000,
    parameter int GAP_TICKS     = 2_500_000,
    parameter int TIMEOUT_TICKS = 250_000_000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic [(1<<DATA_WIDTH)-1:0]   BTN,
    output logic [DATA_WIDTH-1:0]        NOTE_SEL,
    output logic                         NOTE_EN,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
    output logic                         BUSY,
    output logic                         WIN,
    output logic                         LOSE
);

    localparam int LW        = $clog2(DEPTH + 1);
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_A     = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    state_t                state;
    logic [LW-1:0]         len;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [15:0]           lfsr_q;
    logic [DATA_WIDTH-1:0] new_note;
    logic                  last_note;
    logic                  press_ok;
    logic                  unused_lfsr_bits;

    simon_lfsr u_lfsr (
        .CLK (CLK),
        .RST (RST),
        .Q   (lfsr_q)
    );

    assign new_note         = lfsr_q[DATA_WIDTH-1:0];
    assign unused_lfsr_bits = ^lfsr_q[15:DATA_WIDTH];
    assign last_note        = (LW'(idx) == len - LW'(1));
    assign press_ok         = $onehot(BTN) && (onehot_to_index(32'(BTN)) == 5'(mem[idx]));
    assign LEVEL            = len;
    assign BUSY             = (state == S_ADD) || (state == S_PLAY_ON) || (state == S_PLAY_GAP);

    // Sequence storage needs no reset: entries are only read after ADD has written them.
    always_ff @(posedge CLK) begin
        if (state == S_ADD) begin
            mem[len[IW-1:0]] <= new_note;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            len      <= '0;
            idx      <= '0;
            timer    <= '0;
            NOTE_SEL <= '0;
            NOTE_EN  <= 1'b0;
            WIN      <= 1'b0;
            LOSE     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (START) begin
                        len   <= '0;
                        WIN   <= 1'b0;
                        LOSE  <= 1'b0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    len      <= len + LW'(1);
                    idx      <= '0;
                    timer    <= '0;
                    NOTE_EN  <= 1'b1;
                    // mem[0] is being written this same edge on the first round
                    NOTE_SEL <= (len == '0) ? new_note : mem[0];
                    state    <= S_PLAY_ON;
                end
                S_PLAY_ON: begin
                    if (timer == TW'(NOTE_TICKS - 1)) begin
                        timer   <= '0;
                        NOTE_EN <= 1'b0;
                        state   <= S_PLAY_GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_PLAY_GAP: begin
                    if (timer == TW'(GAP_TICKS - 1)) begin
                        timer <= '0;
                        if (last_note) begin
                            idx   <= '0;
                            state <= S_WAIT_IN;
                        end else begin
                            idx      <= idx + IW'(1);
                            NOTE_SEL <= mem[idx + IW'(1)];
                            NOTE_EN  <= 1'b1;
                            state    <= S_PLAY_ON;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (|BTN) begin
                        if (press_ok) begin
                            timer <= '0;
                            if (!last_note) begin
                                idx <= idx + IW'(1);
                            end else if (len < LW'(DEPTH)) begin
                                state <= S_ADD;
                            end else begin
                                WIN   <= 1'b1;
                                state <= S_WIN;
                            end
                        end else begin
                            LOSE  <= 1'b1;
                            state <= S_LOSE;
                        end
                    end else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
                        LOSE  <= 1'b1;
                        state <= S_LOSE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - randomized self-checking bench for simon_sequencer
module tb_simon_sequencer;

    localparam int NOTE_T = 4;
    localparam int GAP_T  = 2;
    localparam int TO_T   = 20;
    localparam int DEPTH  = 4;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       START = 1'b0;
    logic [3:0] BTN   = 4'b0000;
    logic [1:0] NOTE_SEL;
    logic       NOTE_EN;
    logic [2:0] LEVEL;
    logic       BUSY;
    logic       WIN;
    logic       LOSE;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  seq [$];
    logic [1:0]  wrong;

    simon_sequencer #(
        .DATA_WIDTH    (2),
        .DEPTH         (DEPTH),
        .NOTE_TICKS    (NOTE_T),
        .GAP_TICKS     (GAP_T),
        .TIMEOUT_TICKS (TO_T)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .BTN      (BTN),
        .NOTE_SEL (NOTE_SEL),
        .NOTE_EN  (NOTE_EN),
        .LEVEL    (LEVEL),
        .BUSY     (BUSY),
        .WIN      (WIN),
        .LOSE     (LOSE)
    );

    always #5 CLK = ~CLK;

    // Reference LFSR: 16-bit Galois, taps 0xB400, seeded 0xACE1, steps every clock.
    always @(posedge CLK or posedge RST) begin
        if (RST) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called just after the edge that entered ADD: the note stored is the LFSR value now.
    task automatic enter_add();
        check("add_busy", BUSY, 1);
        seq.push_back(m_lfsr[1:0]);
        tick();
        check("level_after_add", LEVEL, seq.size());
    endtask

    task automatic start_game();
        seq.delete();
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_win_clr", WIN, 0);
        check("start_lose_clr", LOSE, 0);
        check("start_level_clr", LEVEL, 0);
        enter_add();
    endtask

    task automatic play_round(input bit poke);
        for (int i = 0; i < seq.size(); i++) begin
            for (int j = 0; j < NOTE_T; j++) begin
                check("note_en_on", NOTE_EN, 1);
                check("note_sel", NOTE_SEL, seq[i]);
                if (poke && j == 1) BTN = 4'($urandom_range(1, 15));
                tick();
                BTN = '0;
            end
            for (int j = 0; j < GAP_T; j++) begin
                check("note_en_gap", NOTE_EN, 0);
                check("busy_gap", BUSY, 1);
                if (poke) begin
                    BTN   = 4'($urandom_range(1, 15));
                    START = 1'b1;
                end
                tick();
                BTN   = '0;
                START = 1'b0;
            end
        end
        check("wait_busy", BUSY, 0);
        check("wait_note_en", NOTE_EN, 0);
        check("wait_level", LEVEL, seq.size());
        check("wait_lose", LOSE, 0);
    endtask

    task automatic echo_round();
        for (int i = 0; i < seq.size(); i++) begin
            repeat ($urandom_range(0, 5)) tick();
            BTN = 4'(1) << seq[i];
            tick();
            BTN = '0;
            if (i < seq.size() - 1) begin
                check("mid_busy", BUSY, 0);
                check("mid_lose", LOSE, 0);
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_note_en", NOTE_EN, 0);
        check("rst_note_sel", NOTE_SEL, 0);
        check("rst_level", LEVEL, 0);
        check("rst_win", WIN, 0);
        check("rst_lose", LOSE, 0);
        check("rst_busy", BUSY, 0);
        RST = 1'b0;
        repeat ($urandom_range(0, 7)) tick();

        // Asynchronous reset in the middle of a played note
        start_game();
        tick();
        check("pre_rst_note_en", NOTE_EN, 1);
        #2 RST = 1'b1;
        #1 check("rst_async_note_en", NOTE_EN, 0);
        check("rst_async_busy", BUSY, 0);
        tick();
        RST = 1'b0;
        check("post_rst_level", LEVEL, 0);
        check("post_rst_win", WIN, 0);
        check("post_rst_lose", LOSE, 0);
        check("post_rst_busy", BUSY, 0);
        repeat ($urandom_range(1, 9)) tick();

        // Full winning game, with ignored BTN/START pokes along the way
        start_game();
        for (int r = 1; r <= DEPTH; r++) begin
            play_round(r == 1);
            if (r == 2) begin
                START = 1'b1;
                tick();
                START = 1'b0;
                check("start_ignored_level", LEVEL, 2);
                check("start_ignored_busy", BUSY, 0);
            end
            echo_round();
            if (r < DEPTH) enter_add();
        end
        check("win_flag", WIN, 1);
        check("win_lose", LOSE, 0);
        check("win_level", LEVEL, DEPTH);
        check("win_busy", BUSY, 0);
        tick();
        check("win_sticky", WIN, 1);
        check("win_level_hold", LEVEL, DEPTH);

        // Wrong note on the first press of round 2
        start_game();
        play_round(0);
        echo_round();
        enter_add();
        play_round(0);
        wrong = seq[0] + 2'($urandom_range(1, 3));
        BTN = 4'(1) << wrong;
        tick();
        BTN = '0;
        check("wrong_lose", LOSE, 1);
        check("wrong_win", WIN, 0);
        check("wrong_level", LEVEL, 2);
        tick();
        check("wrong_lose_sticky", LOSE, 1);

        // Restart from LOSE, then let the press timer expire
        start_game();
        play_round(0);
        repeat (TO_T - 1) tick();
        check("timeout_early", LOSE, 0);
        tick();
        check("timeout_lose", LOSE, 1);
        check("timeout_level", LEVEL, 1);

        // Two buttons at once
        start_game();
        play_round(0);
        BTN = 4'b0011;
        tick();
        BTN = '0;
        check("twohot_lose", LOSE, 1);
        check("twohot_level", LEVEL, 1);
        check("twohot_win", WIN, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
